jtframe_sdram_arb: RTL
======================

Name: jtframe_sdram_arb

Overview:
- Arbitrates the single SDRAM controller port between three game ROM read requesters and the ioctl download write path.
- Sits between the core's ROM fetch logic and the SDRAM controller, so that download writes and game reads share one SDRAM interface without conflict.
- Grants reads round-robin. Download writes have absolute priority while downloading is high.

Parameters:
AW, 22, word address width of read ports and SDRAM side
DW, 16, SDRAM data width (fixed at 16; byte lanes assumed)

Ports:
clk  in  1  system clock (SDRAM clock domain)
rst  in  1  synchronous active-high reset
downloading  in  1  ROM download in progress; blocks new read grants
ioctl_addr  in  22  download byte address
ioctl_data  in  8  download byte
ioctl_wr  in  1  one-cycle write strobe
wr_overrun  out  1  sticky; a write strobe arrived while a write was pending
port0_req / port1_req / port2_req  in  1 each  read request, level, held until ok
port0_addr / port1_addr / port2_addr  in  AW each  read word address, stable while req high
port0_ok / port1_ok / port2_ok  out  1 each  one-cycle pulse: data valid
port0_data / port1_data / port2_data  out  DW each  last word read for that port, held
sdram_req  out  1  access request to SDRAM controller
sdram_addr  out  AW  word address
sdram_we  out  1  1 = write, 0 = read
sdram_din  out  DW  write data
sdram_wrmask  out  2  byte disable, bit set = lane not written
sdram_ack  in  1  controller accepted the request (one-cycle pulse)
data_rdy  in  1  read data valid pulse
data_read  in  DW  read data

Behaviour:
- Reset: all outputs 0, wr_overrun 0, state IDLE, round-robin pointer last=2 (port0 has first priority), pending write cleared.
- Reset mid-operation: immediate return to IDLE. sdram_req drops the next cycle. Any in-flight ok is suppressed.
- Write capture: ioctl_wr with downloading=1 latches addr/data into the pending register and sets wr_pend.
  - ioctl_wr while wr_pend=1 sets wr_overrun and is dropped.
  - ioctl_wr with downloading=0 is ignored.
- States: IDLE, RD_REQ, RD_WAIT, WR_REQ.
- IDLE priority:
  - wr_pend set → WR_REQ.
  - Otherwise, if downloading=0 and any port_req is high → pick the first requesting port after last (modulo 3), register its index and address → RD_REQ.
  - Otherwise stay in IDLE.
- WR_REQ outputs:
  - sdram_req=1, sdram_we=1.
  - sdram_addr = {1'b0, ioctl_addr[21:1]} (latched).
  - sdram_din = {data, data}.
  - sdram_wrmask = 2'b10 when addr[0]=0 (low byte written), 2'b01 when addr[0]=1.
  - On sdram_ack: clear wr_pend, drop sdram_req, → IDLE.
- RD_REQ: sdram_req=1, sdram_we=0, sdram_addr = latched port address.
  - On sdram_ack → RD_WAIT, sdram_req=0.
  - If data_rdy arrives in the same cycle as sdram_ack, finish as in RD_WAIT.
- RD_WAIT: on data_rdy, capture data_read into the granted port's data register, pulse its ok for 1 cycle, set last = granted port, → IDLE.
- Minimum read latency: req seen at cycle N → sdram_req at N+1 → ok no earlier than the cycle after data_rdy.
- A requester dropping req after the grant does not abort the access: the read completes and ok still pulses.
- Requests withdrawn before the grant are not served.
- downloading rising during a read: the read completes normally; no further read grants are made.
- Registered outputs only; no combinational path from the inputs to sdram_req.

Optional Feature:
- Macro JTFRAME_SDRAM_ARB_CACHE_EN.
- When defined, each port keeps a one-entry tag (address + valid).
  - In IDLE, a requesting port whose addr equals its valid tag gets ok pulsed the next cycle without any SDRAM access. Cache hits are evaluated before the round-robin pick and do not advance last.
  - Tags are invalidated by reset and by any ioctl_wr.
- When undefined, every request goes to SDRAM.

Test Plan:
- Reset, then port0 requests addr 0x000100 with the controller returning ack at +1 and data_rdy 0xBEEF at +3 → exactly one read issued; port0_ok pulses once; port0_data = 0xBEEF.
- All three ports request at once → grant order 0,1,2, then 0 again on re-request; each ok occurs only after its own data_rdy.
- downloading=1 and ioctl_wr at ioctl_addr=0x000005, data 0x5A → sdram_addr=0x000002, we=1, din=0x5A5A, wrmask=2'b01; while downloading, port1_req is not granted.
- Two ioctl_wr strobes 1 cycle apart with ack withheld → wr_overrun=1; only the first write is issued; rst clears the flag.
- rst asserted in RD_WAIT → sdram_req=0 and no ok pulse; after reset, port0 has first priority.
- With JTFRAME_SDRAM_ARB_CACHE_EN, port2 reads 0x123 twice → one SDRAM access and two ok pulses. An intervening ioctl_wr forces a second SDRAM access.

Source files
------------

// File: rtl/jtframe_sdram_arb.sv
// SDRAM port arbiter: three round-robin ROM readers plus ioctl download writes.
// Optional per-port one-entry read cache enabled by JTFRAME_SDRAM_ARB_CACHE_EN.
module jtframe_sdram_arb #(
  parameter int AW = 22,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          downloading,
  input  logic [21:0]   ioctl_addr,
  input  logic [7:0]    ioctl_data,
  input  logic          ioctl_wr,
  output logic          wr_overrun,
  input  logic          port0_req,
  input  logic          port1_req,
  input  logic          port2_req,
  input  logic [AW-1:0] port0_addr,
  input  logic [AW-1:0] port1_addr,
  input  logic [AW-1:0] port2_addr,
  output logic          port0_ok,
  output logic          port1_ok,
  output logic          port2_ok,
  output logic [DW-1:0] port0_data,
  output logic [DW-1:0] port1_data,
  output logic [DW-1:0] port2_data,
  output logic          sdram_req,
  output logic [AW-1:0] sdram_addr,
  output logic          sdram_we,
  output logic [DW-1:0] sdram_din,
  output logic [1:0]    sdram_wrmask,
  input  logic          sdram_ack,
  input  logic          data_rdy,
  input  logic [DW-1:0] data_read
);

  typedef enum logic [1:0] {
    IDLE, RD_REQ, RD_WAIT, WR_REQ
  } state_t;

  state_t        st;
  logic [1:0]    last;
  logic [1:0]    gnt;
  logic          wr_pend;
  logic [21:0]   wr_addr;
  logic [7:0]    wr_data;
  logic [2:0]    ok_q;
  logic [DW-1:0] data_q [3];
  logic [AW-1:0] addr_a [3];
  logic [2:0]    req;
  logic [1:0]    pick;
  logic          pick_vld;
  logic          rd_done;
  int            idx;

  assign port0_ok   = ok_q[0];
  assign port1_ok   = ok_q[1];
  assign port2_ok   = ok_q[2];
  assign port0_data = data_q[0];
  assign port1_data = data_q[1];
  assign port2_data = data_q[2];

  // A port whose ok is pulsing now is not re-served on that same cycle
  always_comb begin
    addr_a[0] = port0_addr;
    addr_a[1] = port1_addr;
    addr_a[2] = port2_addr;
    req = {port2_req, port1_req, port0_req} & ~ok_q;
  end

  // Round-robin: first requester after last, scanning backwards keeps the nearest
  always_comb begin
    pick     = 2'd0;
    pick_vld = 1'b0;
    idx      = 0;
    for (int k = 3; k >= 1; k--) begin
      idx = (int'(last) + k) % 3;
      if (req[idx]) begin
        pick     = 2'(idx);
        pick_vld = 1'b1;
      end
    end
  end

  // Read finishes on data_rdy in RD_WAIT, or together with the ack in RD_REQ
  always_comb begin
    rd_done = data_rdy &&
      ((st == RD_WAIT) || (st == RD_REQ && sdram_ack));
  end

`ifdef JTFRAME_SDRAM_ARB_CACHE_EN
  logic [AW-1:0] tag [3];
  logic [2:0]    tag_vld;
  logic [2:0]    hit;
  logic [2:0]    hit_1h;

  // Tag compare per port; lowest-index hit is served first
  always_comb begin
    for (int i = 0; i < 3; i++)
      hit[i] = req[i] && tag_vld[i] && (addr_a[i] == tag[i]);
    hit_1h = hit & (~hit + 3'd1);
  end

  // Tag storage: filled on read completion, flushed by any download write
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_vld <= 3'b0;
      for (int i = 0; i < 3; i++) tag[i] <= '0;
    end else begin
      if (rd_done) begin
        tag[gnt]     <= sdram_addr;
        tag_vld[gnt] <= 1'b1;
      end
      if (ioctl_wr) tag_vld <= 3'b0;
    end
  end
`endif

  // Write capture, arbitration FSM and all registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      st           <= IDLE;
      last         <= 2'd2;
      gnt          <= 2'd0;
      wr_pend      <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= '0;
      wr_overrun   <= 1'b0;
      ok_q         <= 3'b0;
      sdram_req    <= 1'b0;
      sdram_addr   <= '0;
      sdram_we     <= 1'b0;
      sdram_din    <= '0;
      sdram_wrmask <= 2'b0;
      for (int i = 0; i < 3; i++) data_q[i] <= '0;
    end else begin
      ok_q <= 3'b0;
      if (ioctl_wr && downloading) begin
        if (wr_pend) begin
          wr_overrun <= 1'b1;
        end else begin
          wr_pend <= 1'b1;
          wr_addr <= ioctl_addr;
          wr_data <= ioctl_data;
        end
      end
      unique case (st)
        IDLE: begin
          if (wr_pend) begin
            st           <= WR_REQ;
            sdram_req    <= 1'b1;
            sdram_we     <= 1'b1;
            sdram_addr   <= AW'(wr_addr[21:1]);
            sdram_din    <= {wr_data, wr_data};
            sdram_wrmask <= wr_addr[0] ? 2'b01 : 2'b10;
`ifdef JTFRAME_SDRAM_ARB_CACHE_EN
          end else if (!downloading && hit != 3'b0) begin
            ok_q <= hit_1h;
`endif
          end else if (!downloading && pick_vld) begin
            st         <= RD_REQ;
            gnt        <= pick;
            sdram_req  <= 1'b1;
            sdram_we   <= 1'b0;
            sdram_addr <= addr_a[pick];
          end
        end
        RD_REQ: begin
          if (sdram_ack) begin
            sdram_req <= 1'b0;
            st        <= data_rdy ? IDLE : RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (data_rdy) st <= IDLE;
        end
        WR_REQ: begin
          if (sdram_ack) begin
            sdram_req <= 1'b0;
            wr_pend   <= 1'b0;
            st        <= IDLE;
          end
        end
        default: st <= IDLE;
      endcase
      if (rd_done) begin
        data_q[gnt] <= data_read;
        ok_q[gnt]   <= 1'b1;
        last        <= gnt;
      end
    end
  end

endmodule
